// File: rtl/fwrisc_regfile_mp.sv
// Multi-read-port register file for fwrisc: one write port, N registered read ports,
// optional same-edge bypass, optional hardwired-zero entry 0 and a post-reset clear sweep.
module fwrisc_regfile_mp #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned N_RD_PORTS = 2,
  parameter bit          BYPASS     = 1'b1,
  parameter bit          ZERO_REG   = 1'b1,
  parameter bit          INIT_CLEAR = 1'b1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [N_RD_PORTS*ADDR_WIDTH-1:0] rd_raddr_i,
  input  logic [N_RD_PORTS-1:0]            rd_ren_i,
  output logic [N_RD_PORTS*DATA_WIDTH-1:0] rd_rdata_o,
  input  logic [ADDR_WIDTH-1:0]            wr_addr_i,
  input  logic [DATA_WIDTH-1:0]            wr_data_i,
  input  logic                             wr_en_i,
  output logic                             init_busy_o
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  localparam logic [ADDR_WIDTH:0]   DepthExt = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LastIdx  = ADDR_WIDTH'(DEPTH - 1);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   cnt_q;
  logic                    busy_q;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    wr_ok;

  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < DepthExt;
  endfunction

  // A write is only real in RUN, inside the array and not aimed at a hardwired zero.
  always_comb begin
    wr_ok = (state_q == StRun) && wr_en_i && addr_in_range(wr_addr_i) &&
            !(ZERO_REG && (wr_addr_i == '0));
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr_i;
    mem_wdata = wr_data_i;
    if (state_q == StInit) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
    end else if (wr_ok) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= INIT_CLEAR ? StInit : StRun;
      cnt_q   <= '0;
      busy_q  <= INIT_CLEAR;
    end else begin
      unique case (state_q)
        StInit: begin
          if (cnt_q == LastIdx) begin
            state_q <= StRun;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRun: begin
          busy_q <= 1'b0;
        end
        default: begin
          state_q <= StRun;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign init_busy_o = busy_q;

  // Storage has no reset so it can map onto block RAM; the sweep provides known contents.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  for (genvar p = 0; p < N_RD_PORTS; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    assign raddr = rd_raddr_i[p*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rdata_d = '0;
      if (!addr_in_range(raddr)) begin
        rdata_d = '0;
      end else if (ZERO_REG && (raddr == '0)) begin
        rdata_d = '0;
      end else if (BYPASS && wr_ok && (wr_addr_i == raddr)) begin
        rdata_d = wr_data_i;
      end else begin
        rdata_d = mem_q[raddr];
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        rdata_q <= '0;
      end else if (state_q == StInit) begin
        rdata_q <= '0;
      end else if (rd_ren_i[p]) begin
        rdata_q <= rdata_d;
      end
    end

    assign rd_rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = rdata_q;
  end

endmodule

// File: tb/tb_fwrisc_regfile_mp.sv
// Directed bench for fwrisc_regfile_mp: default instance, a read-first instance and a
// 48-entry instance, all sharing the same stimulus.
module tb_fwrisc_regfile_mp;

  logic        clk;
  logic        rst;
  logic [11:0] rd_raddr;
  logic [1:0]  rd_ren;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_en;

  logic [63:0] rdata0, rdata1, rdata2;
  logic        busy0, busy1, busy2;

  int n_cmp  = 0;
  int n_fail = 0;

  fwrisc_regfile_mp u_dut0 (
    .clk_i       (clk),
    .rst_i       (rst),
    .rd_raddr_i  (rd_raddr),
    .rd_ren_i    (rd_ren),
    .rd_rdata_o  (rdata0),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .wr_en_i     (wr_en),
    .init_busy_o (busy0)
  );

  fwrisc_regfile_mp #(.BYPASS(1'b0)) u_dut1 (
    .clk_i       (clk),
    .rst_i       (rst),
    .rd_raddr_i  (rd_raddr),
    .rd_ren_i    (rd_ren),
    .rd_rdata_o  (rdata1),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .wr_en_i     (wr_en),
    .init_busy_o (busy1)
  );

  fwrisc_regfile_mp #(.DEPTH(48)) u_dut2 (
    .clk_i       (clk),
    .rst_i       (rst),
    .rd_raddr_i  (rd_raddr),
    .rd_ren_i    (rd_ren),
    .rd_rdata_o  (rdata2),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .wr_en_i     (wr_en),
    .init_busy_o (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic wen, input logic [5:0] waddr, input logic [31:0] wdata,
                       input logic [1:0] ren, input logic [5:0] ra0, input logic [5:0] ra1);
    wr_en    = wen;
    wr_addr  = waddr;
    wr_data  = wdata;
    rd_ren   = ren;
    rd_raddr = {ra1, ra0};
  endtask

  logic [31:0] hold_exp [3];

  initial begin
    hold_exp[0] = 32'h0A0A_0A0A;
    hold_exp[1] = 32'h0B0B_0B0B;
    hold_exp[2] = 32'h1234_5678;

    rst = 1'b0;
    drive(1'b0, 6'd0, 32'h0, 2'b00, 6'd0, 6'd0);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_busy0", 64'(busy0), 64'd1);
    chk("reset_busy1", 64'(busy1), 64'd1);
    chk("reset_busy2", 64'(busy2), 64'd1);
    chk("reset_rdata0", rdata0, 64'd0);

    // Release reset and try to write/read entry 5 throughout the sweep.
    rst = 1'b0;
    drive(1'b1, 6'd5, 32'hFFFF_FFFF, 2'b11, 6'd5, 6'd5);
    for (int i = 1; i < 64; i++) begin
      @(negedge clk);
      chk("sweep_busy", 64'(busy0), 64'd1);
      chk("sweep_rdata", rdata0, 64'd0);
      if (i == 60) wr_en = 1'b0;
    end
    @(negedge clk);
    chk("sweep_done_busy0", 64'(busy0), 64'd0);
    chk("sweep_done_busy1", 64'(busy1), 64'd0);
    chk("sweep_done_busy2", 64'(busy2), 64'd0);

    for (int a = 0; a < 64; a++) begin
      drive(1'b0, 6'd0, 32'h0, 2'b11, 6'(a), 6'(a));
      @(negedge clk);
      chk("clear_read0", rdata0, 64'd0);
      chk("clear_read1", rdata1, 64'd0);
    end

    // Write then read the same entry on both ports.
    drive(1'b1, 6'd7, 32'hDEAD_BEEF, 2'b00, 6'd0, 6'd0);
    @(negedge clk);
    drive(1'b0, 6'd0, 32'h0, 2'b11, 6'd7, 6'd7);
    @(negedge clk);
    chk("wr7_dut0", rdata0, {32'hDEAD_BEEF, 32'hDEAD_BEEF});
    chk("wr7_dut1", rdata1, {32'hDEAD_BEEF, 32'hDEAD_BEEF});

    // Same-edge write/read of entry 9: bypass versus read-first.
    drive(1'b1, 6'd9, 32'hA5A5_A5A5, 2'b00, 6'd0, 6'd0);
    @(negedge clk);
    drive(1'b1, 6'd9, 32'h1234_5678, 2'b01, 6'd9, 6'd0);
    @(negedge clk);
    chk("bypass_dut0", 64'(rdata0[31:0]), 64'h1234_5678);
    chk("readfirst_dut1", 64'(rdata1[31:0]), 64'hA5A5_A5A5);
    chk("p1_held_dut0", 64'(rdata0[63:32]), 64'hDEAD_BEEF);
    drive(1'b0, 6'd0, 32'h0, 2'b01, 6'd9, 6'd0);
    @(negedge clk);
    chk("readfirst_next_dut1", 64'(rdata1[31:0]), 64'h1234_5678);

    // Hardwired zero entry.
    drive(1'b1, 6'd0, 32'hFFFF_FFFF, 2'b11, 6'd0, 6'd0);
    @(negedge clk);
    chk("zero_bypass_dut0", rdata0, 64'd0);
    chk("zero_bypass_dut2", rdata2, 64'd0);
    drive(1'b0, 6'd0, 32'h0, 2'b11, 6'd0, 6'd0);
    @(negedge clk);
    chk("zero_later_dut0", rdata0, 64'd0);
    chk("zero_later_dut2", rdata2, 64'd0);

    // Address 48 is outside the 48-entry instance but valid in the 64-entry one.
    drive(1'b1, 6'd48, 32'h1111_1111, 2'b11, 6'd48, 6'd48);
    @(negedge clk);
    chk("oor_bypass_dut2", rdata2, 64'd0);
    chk("inr_bypass_dut0", rdata0, {32'h1111_1111, 32'h1111_1111});
    drive(1'b0, 6'd0, 32'h0, 2'b11, 6'd48, 6'd47);
    @(negedge clk);
    chk("oor_later_dut2", rdata2, 64'd0);
    chk("inr_later_dut0", rdata0, {32'h0, 32'h1111_1111});

    // Port 1 disabled for 3 cycles while its address changes.
    drive(1'b1, 6'd10, 32'h0A0A_0A0A, 2'b00, 6'd0, 6'd0);
    @(negedge clk);
    drive(1'b1, 6'd11, 32'h0B0B_0B0B, 2'b00, 6'd0, 6'd0);
    @(negedge clk);
    drive(1'b0, 6'd0, 32'h0, 2'b11, 6'd9, 6'd7);
    @(negedge clk);
    chk("hold_setup", rdata0, {32'hDEAD_BEEF, 32'h1234_5678});
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 6'd0, 32'h0, 2'b01, (i == 2) ? 6'd9 : 6'(10 + i), 6'(12 + i));
      @(negedge clk);
      chk("hold_p0", 64'(rdata0[31:0]), 64'(hold_exp[i]));
      chk("hold_p1", 64'(rdata0[63:32]), 64'hDEAD_BEEF);
    end

    // Reset again, interrupt the sweep at cycle 20, and expect a full restart.
    rst = 1'b1;
    #1;
    chk("async_rst_busy", 64'(busy0), 64'd1);
    chk("async_rst_rdata", rdata0, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 6'd0, 32'h0, 2'b11, 6'd7, 6'd9);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_busy", 64'(busy0), 64'd1);
    rst = 1'b0;
    for (int i = 1; i < 64; i++) begin
      @(negedge clk);
      chk("resweep_busy", 64'(busy0), 64'd1);
      chk("resweep_rdata", rdata0, 64'd0);
    end
    @(negedge clk);
    chk("resweep_done", 64'(busy0), 64'd0);
    for (int a = 0; a < 64; a++) begin
      drive(1'b0, 6'd0, 32'h0, 2'b11, 6'(a), 6'(63 - a));
      @(negedge clk);
      chk("reclear_read0", rdata0, 64'd0);
      chk("reclear_read1", rdata1, 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
